apb_stream_completer: RTL and testbench
=======================================

Name: apb_stream_completer

Overview:
- APB completer that sits behind the host-to-APB bridge.
- Exposes a TX FIFO (host writes → byte stream out) and an RX FIFO (byte stream in → host reads), plus status and control registers.
- Stalls accesses to a full TX FIFO or an empty RX FIFO using apbReady wait states.
- Feeds on-board serial/link engines that produce and consume valid/ready byte streams.

Parameters:
- ADDR_WIDTH, 32: apbAddr width.
- DATA_WIDTH, 32: APB data width; must be ≥ 24.
- REG_LSB, 1: register select is apbAddr[REG_LSB+1:REG_LSB]; all other address bits are ignored.
- STREAM_WIDTH, 8: stream word width; must be ≤ DATA_WIDTH.
- DEPTH, 16: entries per FIFO; power of two, 2..64.
- STALL_TIMEOUT, 256: maximum wait cycles before a blocked access is forced to complete.

Ports:
- clk  in  1  clock; everything is on its rising edge.
- reset  in  1  synchronous, active-high reset.
- apbEnable  in  1  transfer request; held high until apbReady is sampled.
- apbWrite  in  1  1 = write, 0 = read; valid while apbEnable is high.
- apbReady  out  1  transfer completes in a cycle where apbEnable and apbReady are both high.
- apbAddr  in  ADDR_WIDTH  register address.
- apbRData  out  DATA_WIDTH  read data; valid while apbReady is high.
- apbWData  in  DATA_WIDTH  write data; stable while apbEnable is high.
- txData  out  STREAM_WIDTH  TX FIFO head.
- txValid  out  1  TX FIFO is not empty.
- txReady  in  1  consumer pops the TX FIFO when txValid & txReady.
- rxData  in  STREAM_WIDTH  incoming word.
- rxValid  in  1  producer offers a word.
- rxReady  out  1  RX FIFO is not full; push when rxValid & rxReady.

Behaviour:
- Register map (regSel):
  - 0 DATA: write pushes apbWData[STREAM_WIDTH-1:0] into the TX FIFO; read pops the RX FIFO and returns the word zero-extended.
  - 1 STATUS (read-only): [6:0] rxCount, [14:8] txCount, [16] rxEmpty, [17] txFull, [18] rxUnderflow (sticky), [19] txOverflow (sticky); all other bits 0.
  - 2 CONTROL (write-only, reads 0): bit0 flush RX, bit1 flush TX, bit2 clear rxUnderflow, bit3 clear txOverflow.
  - 3: reserved; reads 0, writes ignored.
- "Blocked" means: a DATA write while txFull, or a DATA read while rxEmpty. Every other access is never blocked.
- FSM states:
  - IDLE: when apbEnable is high and the access is not blocked, perform the side effect, register apbRData and go to RESP. When blocked, clear the stall counter and go to STALL.
  - STALL: re-evaluate every cycle. When unblocked, complete normally → RESP. When the counter reaches STALL_TIMEOUT-1, force completion → RESP: a write is dropped and sets txOverflow; a read returns 0 and sets rxUnderflow.
  - RESP: apbReady = 1 for exactly one cycle → RELEASE.
  - RELEASE: wait for apbEnable == 0 → IDLE. This prevents a still-high enable from re-triggering.
- Latency: an unblocked access has apbEnable sampled in cycle 0 and apbReady high in cycle 1.
- Side effects (push, pop, flush, flag clear) occur exactly once per access, on the transition into RESP.
- Reset values: apbReady 0, apbRData 0, txValid 0, rxReady 1, FSM IDLE, both FIFOs empty, sticky flags 0.
- Simultaneous events:
  - Stream pop and APB push on the TX FIFO in the same cycle: both take effect; count is unchanged. When full, a pop in that cycle unblocks the stalled write in the next evaluation.
  - The same rule applies to APB pop and stream push on the RX FIFO.
  - Flush has priority over a same-cycle stream push or pop on that FIFO; the stream word is discarded or not consumed.
  - A flag clear and a flag set in the same cycle: set wins.
- Reset mid-access: all state returns to reset values immediately. If apbEnable is still high afterwards, a fresh access starts from IDLE.
- Counts are DEPTH-inclusive (0..DEPTH). Pointers wrap modulo DEPTH.

Optional Feature:
- Macro: APB_STREAM_COMPLETER_STALL_EN.
- Defined: blocked accesses stall as described above, with the STALL_TIMEOUT bound.
- Undefined: STALL is never entered and STALL_TIMEOUT is unused. A blocked access completes immediately with the forced-completion result (write dropped plus txOverflow; read returns 0 plus rxUnderflow), keeping the 1-cycle latency.

Decomposition:
- Shared package:
  - register select constants REG_DATA, REG_STATUS, REG_CONTROL;
  - STATUS bit positions;
  - CONTROL bit positions;
  - FSM state encoding.
- One sub-module, sync_fifo (DEPTH, WIDTH; push, pop, flush, head, count, empty, full). Instantiated twice.

Test Plan:
- Write DATA 0x000000A5 with the TX FIFO empty → apbReady in cycle 1; txValid=1, txData=0xA5; STATUS[14:8]=1.
- Push 0x3C on the RX stream, then read DATA → apbRData=0x3C; afterwards rxEmpty=1 and STATUS[6:0]=0.
- With STALL_EN: fill TX to 16 and write 0x11 with txReady=0; assert txReady for one cycle at cycle 10 → apbReady at cycle 12; the FIFO holds 16 entries with 0x11 last; txOverflow=0.
- With STALL_EN: read DATA with the RX FIFO empty and no stream input → apbReady at cycle 256; apbRData=0; STATUS[18]=1. Then write CONTROL 0x4 → STATUS[18]=0.
- Push 3 words to RX and 2 to TX, then write CONTROL 0x3 in the same cycle as an RX stream push → both counts are 0 and the pushed word is discarded.
- Assert reset while in STALL with apbEnable high → next cycle apbReady=0 and FIFOs are empty; the held request restarts from IDLE and completes according to the new FIFO state.

Source files
------------

// File: rtl/apb_stream_completer_pkg.sv
// apb_stream_completer_pkg: register map, STATUS/CONTROL bit positions and FSM encoding
// shared by the APB stream completer and its bench.
package apb_stream_completer_pkg;

  // Register select values (address bits [REG_LSB+1:REG_LSB]).
  localparam logic [1:0] REG_DATA    = 2'd0;
  localparam logic [1:0] REG_STATUS  = 2'd1;
  localparam logic [1:0] REG_CONTROL = 2'd2;

  // STATUS fields.
  localparam int unsigned STATUS_RX_COUNT_LSB = 0;
  localparam int unsigned STATUS_TX_COUNT_LSB = 8;
  localparam int unsigned STATUS_COUNT_W      = 7;
  localparam int unsigned STATUS_RX_EMPTY     = 16;
  localparam int unsigned STATUS_TX_FULL      = 17;
  localparam int unsigned STATUS_RX_UNDERFLOW = 18;
  localparam int unsigned STATUS_TX_OVERFLOW  = 19;

  // CONTROL bits.
  localparam int unsigned CTRL_FLUSH_RX = 0;
  localparam int unsigned CTRL_FLUSH_TX = 1;
  localparam int unsigned CTRL_CLR_UNF  = 2;
  localparam int unsigned CTRL_CLR_OVF  = 3;

  typedef enum logic [1:0] {
    StIdle,
    StStall,
    StResp,
    StRelease
  } state_e;

endpackage

// File: rtl/apb_stream_completer_sync_fifo.sv
// apb_stream_completer_sync_fifo: single-clock FIFO with flush, head peek and
// DEPTH-inclusive occupancy count. Push when full and pop when empty are ignored.
module apb_stream_completer_sync_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  input  logic [WIDTH-1:0]         data_i,
  output logic [WIDTH-1:0]         head_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     empty_o,
  output logic                     full_o
);
  localparam int unsigned PtrW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wptr_q, rptr_q;
  logic [PtrW:0]    count_q;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (PtrW+1)'(DEPTH));
  assign count_o = count_q;
  assign head_o  = mem_q[rptr_q];
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  // Pointer and count update; flush wins over any same-cycle push or pop.
  always_ff @(posedge clk_i) begin
    if (reset_i || flush_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      if (do_push && !do_pop)      count_q <= count_q + 1'b1;
      else if (do_pop && !do_push) count_q <= count_q - 1'b1;
    end
  end

  // Storage write; contents need no reset since count gates visibility.
  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) mem_q[wptr_q] <= data_i;
  end

endmodule

// File: rtl/apb_stream_completer.sv
// apb_stream_completer: APB completer exposing a TX byte FIFO, an RX byte FIFO and
// STATUS/CONTROL registers. Macro APB_STREAM_COMPLETER_STALL_EN: when defined, blocked
// accesses wait (up to STALL_TIMEOUT cycles); when undefined they complete immediately
// with the forced result (write dropped + txOverflow, read returns 0 + rxUnderflow).
module apb_stream_completer
  import apb_stream_completer_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH    = 32,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned REG_LSB       = 1,
  parameter int unsigned STREAM_WIDTH  = 8,
  parameter int unsigned DEPTH         = 16,
  parameter int unsigned STALL_TIMEOUT = 256
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    apb_enable_i,
  input  logic                    apb_write_i,
  output logic                    apb_ready_o,
  input  logic [ADDR_WIDTH-1:0]   apb_addr_i,
  output logic [DATA_WIDTH-1:0]   apb_rdata_o,
  input  logic [DATA_WIDTH-1:0]   apb_wdata_i,
  output logic [STREAM_WIDTH-1:0] tx_data_o,
  output logic                    tx_valid_o,
  input  logic                    tx_ready_i,
  input  logic [STREAM_WIDTH-1:0] rx_data_i,
  input  logic                    rx_valid_i,
  output logic                    rx_ready_o
);
  localparam int unsigned CountW = $clog2(DEPTH) + 1;

  if (DATA_WIDTH < 24) begin : gen_chk_data_width
    $error("DATA_WIDTH must be at least 24");
  end
  if (STREAM_WIDTH > DATA_WIDTH) begin : gen_chk_stream_width
    $error("STREAM_WIDTH must not exceed DATA_WIDTH");
  end
  if (DEPTH < 2 || DEPTH > 64 || (DEPTH & (DEPTH - 1)) != 0) begin : gen_chk_depth
    $error("DEPTH must be a power of two in 2..64");
  end
  if (STALL_TIMEOUT < 2) begin : gen_chk_timeout
    $error("STALL_TIMEOUT must be at least 2");
  end

  state_e                  state_q, state_d;
  logic [1:0]              reg_sel;
  logic                    blocked, complete, forced;
  logic                    tx_push, tx_pop, tx_flush, tx_empty, tx_full;
  logic                    rx_push, rx_pop, rx_flush, rx_empty, rx_full;
  logic [CountW-1:0]       tx_count, rx_count;
  logic [STREAM_WIDTH-1:0] rx_head;
  logic                    unf_q, ovf_q, set_unf, set_ovf, clr_unf, clr_ovf;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d, status;
  logic                    unused_ok;

`ifdef APB_STREAM_COMPLETER_STALL_EN
  localparam int unsigned CntW = $clog2(STALL_TIMEOUT);
  logic [CntW-1:0] cnt_q, cnt_d, cnt_inc;
  // Counter value including the current stall cycle.
  assign cnt_inc = cnt_q + 1'b1;
`endif

  assign reg_sel   = apb_addr_i[REG_LSB+1:REG_LSB];
  assign blocked   = (reg_sel == REG_DATA) & (apb_write_i ? tx_full : rx_empty);
  assign unused_ok = ^{apb_addr_i, apb_wdata_i};

  assign apb_ready_o = (state_q == StResp);
  assign apb_rdata_o = rdata_q;
  assign tx_valid_o  = ~tx_empty;
  assign rx_ready_o  = ~rx_full;
  assign tx_pop      = tx_ready_i & ~tx_empty;
  assign rx_push     = rx_valid_i & ~rx_full;

  apb_stream_completer_sync_fifo #(.DEPTH(DEPTH), .WIDTH(STREAM_WIDTH)) u_tx_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .push_i  (tx_push),
    .pop_i   (tx_pop),
    .flush_i (tx_flush),
    .data_i  (apb_wdata_i[STREAM_WIDTH-1:0]),
    .head_o  (tx_data_o),
    .count_o (tx_count),
    .empty_o (tx_empty),
    .full_o  (tx_full)
  );

  apb_stream_completer_sync_fifo #(.DEPTH(DEPTH), .WIDTH(STREAM_WIDTH)) u_rx_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .push_i  (rx_push),
    .pop_i   (rx_pop),
    .flush_i (rx_flush),
    .data_i  (rx_data_i),
    .head_o  (rx_head),
    .count_o (rx_count),
    .empty_o (rx_empty),
    .full_o  (rx_full)
  );

  // STATUS register image from live FIFO state and sticky flags.
  always_comb begin
    status = '0;
    status[STATUS_RX_COUNT_LSB +: STATUS_COUNT_W] = STATUS_COUNT_W'(rx_count);
    status[STATUS_TX_COUNT_LSB +: STATUS_COUNT_W] = STATUS_COUNT_W'(tx_count);
    status[STATUS_RX_EMPTY]     = rx_empty;
    status[STATUS_TX_FULL]      = tx_full;
    status[STATUS_RX_UNDERFLOW] = unf_q;
    status[STATUS_TX_OVERFLOW]  = ovf_q;
  end

  // Access FSM: decides when an access completes and whether it is forced.
  always_comb begin
    state_d  = state_q;
    complete = 1'b0;
    forced   = 1'b0;
`ifdef APB_STREAM_COMPLETER_STALL_EN
    cnt_d    = cnt_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (apb_enable_i) begin
          state_d = StResp;
          if (!blocked) begin
            complete = 1'b1;
          end else begin
`ifdef APB_STREAM_COMPLETER_STALL_EN
            cnt_d   = '0;
            state_d = StStall;
`else
            complete = 1'b1;
            forced   = 1'b1;
`endif
          end
        end
      end
      StStall: begin
`ifdef APB_STREAM_COMPLETER_STALL_EN
        if (!blocked) begin
          complete = 1'b1;
          state_d  = StResp;
        end else if (cnt_inc == CntW'(STALL_TIMEOUT - 1)) begin
          complete = 1'b1;
          forced   = 1'b1;
          state_d  = StResp;
        end else begin
          cnt_d = cnt_inc;
        end
`else
        state_d = StIdle;
`endif
      end
      StResp:    state_d = StRelease;
      StRelease: if (!apb_enable_i) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // Side effects and read data, applied only on the completing cycle.
  always_comb begin
    tx_push  = 1'b0;
    rx_pop   = 1'b0;
    tx_flush = 1'b0;
    rx_flush = 1'b0;
    clr_unf  = 1'b0;
    clr_ovf  = 1'b0;
    set_unf  = 1'b0;
    set_ovf  = 1'b0;
    rdata_d  = rdata_q;
    if (complete) begin
      rdata_d = '0;
      if (forced) begin
        set_ovf = apb_write_i;
        set_unf = ~apb_write_i;
      end else if (apb_write_i) begin
        case (reg_sel)
          REG_DATA: tx_push = 1'b1;
          REG_CONTROL: begin
            rx_flush = apb_wdata_i[CTRL_FLUSH_RX];
            tx_flush = apb_wdata_i[CTRL_FLUSH_TX];
            clr_unf  = apb_wdata_i[CTRL_CLR_UNF];
            clr_ovf  = apb_wdata_i[CTRL_CLR_OVF];
          end
          default: ;
        endcase
      end else begin
        case (reg_sel)
          REG_DATA: begin
            rx_pop                       = 1'b1;
            rdata_d[STREAM_WIDTH-1:0]    = rx_head;
          end
          REG_STATUS: rdata_d = status;
          default: ;
        endcase
      end
    end
  end

  // State, read data and sticky flags; a same-cycle set beats a clear.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= StIdle;
      rdata_q <= '0;
      unf_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
      unf_q   <= (unf_q & ~clr_unf) | set_unf;
      ovf_q   <= (ovf_q & ~clr_ovf) | set_ovf;
    end
  end

`ifdef APB_STREAM_COMPLETER_STALL_EN
  // Stall wait counter.
  always_ff @(posedge clk_i) begin
    if (reset_i) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end
`endif

endmodule

// File: tb/tb_apb_stream_completer.sv
// tb_apb_stream_completer: directed and randomized checks of apb_stream_completer against a
// queue-based transaction model. Honours APB_STREAM_COMPLETER_STALL_EN.
`timescale 1ns/1ps
module tb_apb_stream_completer;
  localparam int unsigned DEPTH   = 16;
  localparam int unsigned TIMEOUT = 256;
`ifdef APB_STREAM_COMPLETER_STALL_EN
  localparam bit StallEn = 1'b1;
`else
  localparam bit StallEn = 1'b0;
`endif

  logic        clk = 1'b0, reset = 1'b1;
  logic        en = 1'b0, wr = 1'b0;
  logic [31:0] addr = '0, wdata = '0;
  logic        rdy, tx_valid, rx_ready;
  logic [31:0] rdata;
  logic [7:0]  tx_data;
  logic        tx_ready = 1'b0, rx_valid = 1'b0;
  logic [7:0]  rx_data = '0;

  int checks = 0, errors = 0;
  bit rand_stream = 1'b0, bias = 1'b0;

  always #5 clk = ~clk;

  apb_stream_completer #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .REG_LSB(1), .STREAM_WIDTH(8),
    .DEPTH(DEPTH), .STALL_TIMEOUT(TIMEOUT)
  ) dut (
    .clk_i        (clk),
    .reset_i      (reset),
    .apb_enable_i (en),
    .apb_write_i  (wr),
    .apb_ready_o  (rdy),
    .apb_addr_i   (addr),
    .apb_rdata_o  (rdata),
    .apb_wdata_i  (wdata),
    .tx_data_o    (tx_data),
    .tx_valid_o   (tx_valid),
    .tx_ready_i   (tx_ready),
    .rx_data_i    (rx_data),
    .rx_valid_i   (rx_valid),
    .rx_ready_o   (rx_ready)
  );

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  // ---------------- behavioural model ----------------
  int          txq[$], rxq[$];
  bit          m_unf, m_ovf, exp_ready, exp_read, need_low, started;
  int          waited;
  logic [31:0] exp_rdata;
  int          tx_n, rx_n, sel;
  bit          s_pop, s_push, done, forced, blk;
  bit          a_push, a_pop, f_rx, f_tx, c_unf, c_ovf, s_unf, s_ovf;
  logic [31:0] rd;

  always @(posedge clk) begin
    started = 1'b1;
    if (reset) begin
      txq.delete(); rxq.delete();
      m_unf = 0; m_ovf = 0; exp_ready = 0; need_low = 0; waited = 0;
    end else begin
      tx_n = txq.size(); rx_n = rxq.size();
      s_pop  = (tx_n > 0) && tx_ready;
      s_push = rx_valid && (rx_n < DEPTH);
      done = 0; forced = 0; a_push = 0; a_pop = 0; f_rx = 0; f_tx = 0;
      c_unf = 0; c_ovf = 0; s_unf = 0; s_ovf = 0;
      sel = int'(addr[2:1]);
      if (exp_ready) begin
        exp_ready = 0; need_low = 1;
      end else if (need_low) begin
        if (!en) need_low = 0;
      end else if (en) begin
        blk = (sel == 0) && (wr ? (tx_n == DEPTH) : (rx_n == 0));
        if (!blk) done = 1;
        else begin
          waited++;
          if (!StallEn || waited == TIMEOUT) begin done = 1; forced = 1; end
        end
      end
      if (done) begin
        waited = 0; exp_ready = 1; exp_read = !wr; rd = '0;
        if (forced) begin
          if (wr) s_ovf = 1; else s_unf = 1;
        end else if (wr) begin
          if (sel == 0) a_push = 1;
          else if (sel == 2) begin
            f_rx = wdata[0]; f_tx = wdata[1]; c_unf = wdata[2]; c_ovf = wdata[3];
          end
        end else if (sel == 0) begin
          a_pop = 1; rd = 32'(rxq[0]);
        end else if (sel == 1) begin
          rd[6:0] = 7'(rx_n); rd[14:8] = 7'(tx_n);
          rd[16] = (rx_n == 0); rd[17] = (tx_n == DEPTH); rd[18] = m_unf; rd[19] = m_ovf;
        end
        exp_rdata = rd;
      end
      if (f_tx) txq.delete();
      else begin
        if (s_pop) void'(txq.pop_front());
        if (a_push) txq.push_back(int'(wdata[7:0]));
      end
      if (f_rx) rxq.delete();
      else begin
        if (a_pop) void'(rxq.pop_front());
        if (s_push) rxq.push_back(int'(rx_data));
      end
      m_unf = (m_unf && !c_unf) || s_unf;
      m_ovf = (m_ovf && !c_ovf) || s_ovf;
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    if (started) begin
      chk("apb_ready", 32'(rdy), 32'(exp_ready));
      if (exp_ready && exp_read) chk("apb_rdata", rdata, exp_rdata);
      chk("tx_valid", 32'(tx_valid), 32'(txq.size() > 0));
      if (txq.size() > 0) chk("tx_data", 32'(tx_data), 32'(txq[0]));
      chk("rx_ready", 32'(rx_ready), 32'(rxq.size() < DEPTH));
    end
  end

  // Random stream partners.
  always @(negedge clk) begin
    if (rand_stream) begin
      tx_ready = bias ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 3) != 0);
      rx_valid = bias ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 7) == 0);
      rx_data  = 8'($urandom);
    end
  end

  // ---------------- drivers ----------------
  task automatic apb(input bit w, input logic [1:0] s, input logic [31:0] d, input int hold,
                     output logic [31:0] r, output int lat);
    @(negedge clk);
    en = 1'b1; wr = w; addr = $urandom; addr[2:1] = s; wdata = d;
    lat = 0; r = '0;
    checks++;
    while (1) begin
      @(posedge clk); #1; lat++;
      if (rdy) begin r = rdata; break; end
      if (lat > TIMEOUT + 20) begin
        errors++;
        $display("FAIL apb_timeout: got no ready after %0d cycles expected ready", lat);
        break;
      end
    end
    @(posedge clk);
    repeat (hold) @(posedge clk);
    @(negedge clk);
    en = 1'b0;
  endtask

  task automatic rx_word(input logic [7:0] d);
    @(negedge clk); rx_valid = 1'b1; rx_data = d;
    @(negedge clk); rx_valid = 1'b0;
  endtask

  logic [31:0] r;
  int          lat;
  logic [7:0]  first_b, last_b;

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ready", 32'(rdy), 32'd0);
    chk("reset_rdata", rdata, 32'd0);
    chk("reset_tx_valid", 32'(tx_valid), 32'd0);
    chk("reset_rx_ready", 32'(rx_ready), 32'd1);
    @(negedge clk); reset = 1'b0;

    // TX write.
    apb(1, 2'd0, 32'h0000_00A5, 0, r, lat);
    chk("wr_latency", 32'(lat), 32'd1);
    chk("tx_data_a5", 32'(tx_data), 32'hA5);
    chk("tx_valid_a5", 32'(tx_valid), 32'd1);
    apb(0, 2'd1, 32'h0, 0, r, lat);
    chk("status_tx1", r, 32'h0001_0100);

    // RX read.
    rx_word(8'h3C);
    apb(0, 2'd0, 32'h0, 0, r, lat);
    chk("rd_latency", 32'(lat), 32'd1);
    chk("rd_3c", r, 32'h3C);
    apb(0, 2'd1, 32'h0, 0, r, lat);
    chk("status_rx_empty", r, 32'h0001_0100);

    // Read of an empty RX FIFO.
    apb(0, 2'd0, 32'h0, 0, r, lat);
    chk("unf_latency", 32'(lat), StallEn ? 32'd256 : 32'd1);
    chk("unf_rdata", r, 32'h0);
    apb(0, 2'd1, 32'h0, 0, r, lat);
    chk("status_unf", r, 32'h0005_0100);
    apb(1, 2'd2, 32'h4, 0, r, lat);
    apb(0, 2'd1, 32'h0, 0, r, lat);
    chk("status_unf_clr", r, 32'h0001_0100);

    // Fill TX to DEPTH, then write to a full FIFO.
    for (int i = 1; i < 16; i++) apb(1, 2'd0, 32'(i), 0, r, lat);
    apb(0, 2'd1, 32'h0, 0, r, lat);
    chk("status_tx_full", r, 32'h0003_1000);
    fork
      apb(1, 2'd0, 32'h11, 0, r, lat);
      begin
        @(negedge clk); @(posedge clk);
        repeat (9) @(posedge clk);
        if (StallEn) begin
          @(negedge clk); tx_ready = 1'b1;
          @(negedge clk); tx_ready = 1'b0;
        end
      end
    join
    chk("full_wr_latency", 32'(lat), StallEn ? 32'd12 : 32'd1);
    apb(0, 2'd1, 32'h0, 0, r, lat);
    chk("status_full_wr", r, StallEn ? 32'h0003_1000 : 32'h000B_1000);
    @(negedge clk); tx_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (i == 0) first_b = tx_data;
      last_b = tx_data;
      @(negedge clk);
    end
    tx_ready = 1'b0;
    chk("drain_first", 32'(first_b), StallEn ? 32'h01 : 32'hA5);
    chk("drain_last", 32'(last_b), StallEn ? 32'h11 : 32'h0F);
    apb(1, 2'd2, 32'h8, 0, r, lat);
    apb(0, 2'd1, 32'h0, 0, r, lat);
    chk("status_drained", r, 32'h0001_0000);

    // Flush both FIFOs with a same-cycle RX stream push.
    rx_word(8'h01); rx_word(8'h02); rx_word(8'h03);
    apb(1, 2'd0, 32'h21, 0, r, lat);
    apb(1, 2'd0, 32'h22, 0, r, lat);
    fork
      apb(1, 2'd2, 32'h3, 0, r, lat);
      begin
        @(negedge clk); rx_valid = 1'b1; rx_data = 8'h99;
        @(negedge clk); rx_valid = 1'b0;
      end
    join
    apb(0, 2'd1, 32'h0, 0, r, lat);
    chk("status_flushed", r, 32'h0001_0000);
    chk("flush_tx_valid", 32'(tx_valid), 32'd0);

    // Reset while an access to an empty RX FIFO is outstanding.
    @(negedge clk); en = 1'b1; wr = 1'b0; addr = 32'h0; wdata = '0;
    repeat (5) @(posedge clk);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    chk("midrst_ready", 32'(rdy), 32'd0);
    chk("midrst_tx_valid", 32'(tx_valid), 32'd0);
    chk("midrst_rx_ready", 32'(rx_ready), 32'd1);
    @(negedge clk); reset = 1'b0; rx_valid = 1'b1; rx_data = 8'h77;
    lat = 0; r = '0;
    checks++;
    while (1) begin
      @(posedge clk); #1; lat++;
      rx_valid = 1'b0;
      if (rdy) begin r = rdata; break; end
      if (lat > TIMEOUT + 20) begin
        errors++;
        $display("FAIL midrst_timeout: got no ready after %0d cycles expected ready", lat);
        break;
      end
    end
    chk("midrst_latency", 32'(lat), StallEn ? 32'd2 : 32'd1);
    chk("midrst_rdata", r, StallEn ? 32'h77 : 32'h0);
    @(posedge clk);
    @(negedge clk); en = 1'b0;
    apb(0, 2'd1, 32'h0, 0, r, lat);
    chk("midrst_status", r, StallEn ? 32'h0001_0000 : 32'h0004_0001);
    apb(1, 2'd2, 32'hF, 0, r, lat);

    // Randomized traffic, alternating which side of each FIFO is starved.
    rand_stream = 1'b1;
    for (int n = 0; n < 300; n++) begin
      int          k;
      logic [1:0]  s;
      logic [31:0] d;
      if (n % 50 == 0) bias = ~bias;
      k = $urandom_range(0, 9);
      s = (k < 6) ? 2'd0 : (k < 8) ? 2'd1 : (k == 8) ? 2'd2 : 2'd3;
      d = $urandom;
      if (s == 2'd2 && $urandom_range(0, 3) != 0) d = d & 32'hFFFF_FFFC;
      apb(1'($urandom), s, d, $urandom_range(0, 2), r, lat);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    rand_stream = 1'b0;
    @(negedge clk); tx_ready = 1'b0; rx_valid = 1'b0;
    repeat (4) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
